program_loader: RTL

Front-end stage that owns the 32-entry, 19-bit instruction store feeding the single-cycle CPU's fetch port. It accepts a program as a stream of 19-bit words over a valid/ready handshake and writes them sequentially from address 0. It holds the CPU in reset while loading, then releases it. Words beyond the loaded length read back as zero, so a partially filled store never exposes stale contents.

---
 rtl/program_loader.sv | 100 ++++++++++
 1 files changed

// File: rtl/program_loader.sv
// Instruction store loader: streams a program into a 32-entry store over valid/ready,
// holding the CPU in reset until the requested number of words has arrived.
module program_loader #(
  parameter int DATA_WIDTH = 19,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH:0]   load_count,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] fetch_address,
  output logic [DATA_WIDTH-1:0] fetch_instruction,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE       = (ADDR_WIDTH + 1)'(1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t                state;
  state_t                next_state;
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   target;
  logic [ADDR_WIDTH:0]   clamped_count;
  logic                  start_ok;
  logic                  accept;
  logic                  last_accept;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign clamped_count = (load_count > DEPTH_CNT) ? DEPTH_CNT : load_count;

  always_comb begin
    next_state  = state;
    start_ok    = 1'b0;
    accept      = 1'b0;
    last_accept = 1'b0;
    unique case (state)
      IDLE, RUN: begin
        if (load_start && (load_count != '0)) begin
          start_ok   = 1'b1;
          next_state = LOAD;
        end
      end
      LOAD: begin
        if (in_valid) begin
          accept = 1'b1;
          if ((wr_ptr + ONE) == target) begin
            last_accept = 1'b1;
            next_state  = RUN;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Status outputs are registered from next_state so they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      target    <= '0;
      cpu_reset <= 1'b1;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= next_state;
      cpu_reset <= (next_state != RUN);
      in_ready  <= (next_state == LOAD);
      busy      <= (next_state == LOAD);
      done      <= last_accept;
      if (start_ok) begin
        wr_ptr <= '0;
        target <= clamped_count;
      end else if (accept) begin
        wr_ptr <= wr_ptr + ONE;
      end
    end
  end

  // The store itself is never cleared; words_loaded masks anything not written by the current load.
  always_ff @(posedge clk) begin
    if (accept && !reset) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= in_data;
    end
  end

  assign words_loaded      = wr_ptr;
  assign fetch_instruction = ({1'b0, fetch_address} < words_loaded) ? mem[fetch_address] : '0;

endmodule
